masked_adder_serial: RTL

- Two-share Boolean-masked W-bit adder/subtractor. Generalises the masked half adder to full words: one bit per cycle (ripple-serial), carry held in a two-share register.
- One masked AND gadget per bit, fed one fresh random bit per cycle.
- Sits between share-generation logic and downstream masked datapaths. Valid/ready handshakes on both sides.
- Unmasked values never appear on any wire or register.

---
 rtl/masked_adder_serial.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/masked_adder_serial.sv
// Two-share Boolean-masked W-bit adder/subtractor, one bit per cycle.
// The carry is held as two shares and refreshed through one masked AND gadget per bit.
module masked_adder_serial #(
    parameter int W      = 8,
    parameter bit SUB_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] b1,
    input  logic         sub,
    input  logic         rnd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum0,
    output logic [W-1:0] sum1,
    output logic         cout0,
    output logic         cout1
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  a0_q, a1_q, b0_q, b1_q;
    logic [W-1:0]  s0_acc, s1_acc;
    logic          c0, c1;
    logic          sub_eff, last;
    logic          x0, x1, y0, y1;
    logic          bit_s0, bit_s1;
    logic          cross01, cross10;
    logic          c0_nxt, c1_nxt;

    assign sub_eff = SUB_EN ? sub : 1'b0;
    assign last    = (idx == IW'(W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift right, so the active bit is always at position 0.
    assign x0     = a0_q[0] ^ c0;
    assign x1     = a1_q[0] ^ c1;
    assign y0     = b0_q[0] ^ c0;
    assign y1     = b1_q[0] ^ c1;
    assign bit_s0 = a0_q[0] ^ b0_q[0] ^ c0;
    assign bit_s1 = a1_q[0] ^ b1_q[0] ^ c1;

    // Cross-domain products are blinded by rnd before meeting the same-domain term.
    assign cross01 = (x0 & y1) ^ rnd;
    assign cross10 = (x1 & y0) ^ rnd;
    assign c0_nxt  = (x0 & y0) ^ cross01 ^ c0;
    assign c1_nxt  = (x1 & y1) ^ cross10 ^ c1;

    // NOTE: these are plain flops, not a memory array, so all of them are reset; no stale
    // share from an aborted operation survives a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a0_q   <= '0;
            a1_q   <= '0;
            b0_q   <= '0;
            b1_q   <= '0;
            s0_acc <= '0;
            s1_acc <= '0;
            c0     <= 1'b0;
            c1     <= 1'b0;
            idx    <= '0;
            sum0   <= '0;
            sum1   <= '0;
            cout0  <= 1'b0;
            cout1  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a0_q <= a0;
                        a1_q <= a1;
                        b0_q <= sub_eff ? ~b0 : b0;
                        b1_q <= b1;
                        c0   <= sub_eff;
                        c1   <= 1'b0;
                        idx  <= '0;
                    end
                end
                RUN: begin
                    a0_q   <= a0_q >> 1;
                    a1_q   <= a1_q >> 1;
                    b0_q   <= b0_q >> 1;
                    b1_q   <= b1_q >> 1;
                    s0_acc <= {bit_s0, s0_acc[W-1:1]};
                    s1_acc <= {bit_s1, s1_acc[W-1:1]};
                    c0     <= c0_nxt;
                    c1     <= c1_nxt;
                    idx    <= idx + IW'(1);
                    if (last) begin
                        sum0  <= {bit_s0, s0_acc[W-1:1]};
                        sum1  <= {bit_s1, s1_acc[W-1:1]};
                        cout0 <= c0_nxt;
                        cout1 <= c1_nxt;
                        idx   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
